pkt_fifo_drain: RTL and testbench

- Read-side consumer for the team's 4-deep synchronous packet FIFO. A packet is {src[7:0], dst[7:0], data[31:0]}.
- Pops one packet at a time by pulsing the FIFO read strobe, then captures the registered FIFO output one cycle later.
- Filters each packet on destination address. Accepted packets go out on a valid/ready port to the downstream router. Rejected packets are dropped and flagged.

---
 rtl/pkt_fifo_drain.sv | 170 +++++++++++++++++
 tb/tb_pkt_fifo_drain.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : pkt_fifo_drain
// Brief    : Read-side consumer for the 4-deep synchronous packet FIFO.
//            Pops one packet at a time, captures the registered FIFO output,
//            forwards packets addressed to PORT_ADDR or BCAST_ADDR on a
//            valid/ready port and drops the rest with a one-cycle pulse.
//            Optional statistics counters are built when the macro
//            PKT_DRAIN_STATS_EN is defined (adds stats_clr, pkt_cnt,
//            drop_cnt and parameter CNT_W).
// Revision : 1.0 - initial release
// ============================================================================
module pkt_fifo_drain #(
   parameter logic [7:0] PORT_ADDR  = 8'h01,
   parameter logic [7:0] BCAST_ADDR = 8'hFF
`ifdef PKT_DRAIN_STATS_EN
   ,
   parameter int unsigned CNT_W = 16
`endif
) (
   input  logic        clk,
   input  logic        rstp,
   input  logic        en,
   input  logic        fifo_emptyp,
   output logic        fifo_readp,
   input  logic [7:0]  fifo_src,
   input  logic [7:0]  fifo_dst,
   input  logic [31:0] fifo_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_src,
   output logic [7:0]  out_dst,
   output logic [31:0] out_data,
   output logic        drop_pulse,
   output logic        busy
`ifdef PKT_DRAIN_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_CAPT = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_fifo_readp;
   logic        r_out_valid;
   logic        r_busy;
   logic        r_drop_pulse;
   logic [7:0]  r_out_src;
   logic [7:0]  r_out_dst;
   logic [31:0] r_out_data;

   logic        w_accept;
   logic        w_handshake;
   logic        w_start_pop;
   logic        w_drop_evt;

   // Destination filter and event decode from the current state.
   assign w_accept    = (fifo_dst == PORT_ADDR) || (fifo_dst == BCAST_ADDR);
   assign w_handshake = (r_state == ST_OUT) && out_ready;
   assign w_start_pop = en && !fifo_emptyp;
   assign w_drop_evt  = (r_state == ST_CAPT) && !w_accept;

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_pop) begin
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            w_state_nxt = ST_CAPT;
         end
         ST_CAPT: begin
            w_state_nxt = w_accept ? ST_OUT : ST_IDLE;
         end
         ST_OUT: begin
            if (w_handshake) begin
               w_state_nxt = w_start_pop ? ST_READ : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; strobes are registered from the next state so they are
   // driven straight from flops and cannot glitch.
   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         r_state      <= ST_IDLE;
         r_fifo_readp <= 1'b0;
         r_out_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_fifo_readp <= (w_state_nxt == ST_READ);
         r_out_valid  <= (w_state_nxt == ST_OUT);
         r_busy       <= (w_state_nxt != ST_IDLE);
      end
   end

   // Capture the popped packet at the end of CAPT and flag rejected ones.
   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         r_out_src    <= 8'h00;
         r_out_dst    <= 8'h00;
         r_out_data   <= 32'h0000_0000;
         r_drop_pulse <= 1'b0;
      end else begin
         r_drop_pulse <= w_drop_evt;
         if (r_state == ST_CAPT) begin
            r_out_src  <= fifo_src;
            r_out_dst  <= fifo_dst;
            r_out_data <= fifo_data;
         end
      end
   end

   assign fifo_readp = r_fifo_readp;
   assign out_valid  = r_out_valid;
   assign busy       = r_busy;
   assign drop_pulse = r_drop_pulse;
   assign out_src    = r_out_src;
   assign out_dst    = r_out_dst;
   assign out_data   = r_out_data;

`ifdef PKT_DRAIN_STATS_EN
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_pkt_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   // Saturating statistics counters; a clear overrides a same-cycle count.
   always_ff @(posedge clk or posedge rstp) begin
      if (rstp) begin
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else if (stats_clr) begin
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_handshake && (r_pkt_cnt != c_cnt_max)) begin
            r_pkt_cnt <= r_pkt_cnt + c_cnt_one;
         end
         if (w_drop_evt && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + c_cnt_one;
         end
      end
   end

   assign pkt_cnt  = r_pkt_cnt;
   assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_fifo_drain
// Brief    : Self-checking bench for pkt_fifo_drain with a behavioural
//            4-deep FIFO and an in-order filtered-packet reference queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_fifo_drain;

   localparam logic [7:0] PORT  = 8'h01;
   localparam logic [7:0] BCAST = 8'hFF;

   logic        clk = 1'b0;
   logic        rstp = 1'b0;
   logic        en = 1'b0;
   logic        fifo_emptyp = 1'b1;
   logic        fifo_readp;
   logic [7:0]  fifo_src = 8'h00;
   logic [7:0]  fifo_dst = 8'h00;
   logic [31:0] fifo_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_src;
   logic [7:0]  out_dst;
   logic [31:0] out_data;
   logic        drop_pulse;
   logic        busy;
`ifdef PKT_DRAIN_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;
`endif

   pkt_fifo_drain #(
      .PORT_ADDR  (PORT),
      .BCAST_ADDR (BCAST)
   ) dut (
      .clk         (clk),
      .rstp        (rstp),
      .en          (en),
      .fifo_emptyp (fifo_emptyp),
      .fifo_readp  (fifo_readp),
      .fifo_src    (fifo_src),
      .fifo_dst    (fifo_dst),
      .fifo_data   (fifo_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_src     (out_src),
      .out_dst     (out_dst),
      .out_data    (out_data),
      .drop_pulse  (drop_pulse),
      .busy        (busy)
`ifdef PKT_DRAIN_STATS_EN
      ,
      .stats_clr   (stats_clr),
      .pkt_cnt     (pkt_cnt),
      .drop_cnt    (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: registered output, one-cycle read latency.
   logic        wr_en = 1'b0;
   logic [47:0] wr_pkt = 48'h0;
   logic [47:0] fq[$];
   int          fifo_level = 0;

   always @(posedge clk or posedge rstp) begin
      if (rstp) begin
         fq.delete();
         fifo_emptyp <= 1'b1;
         fifo_level  <= 0;
      end else begin
         if (fifo_readp && fq.size() > 0) begin
            {fifo_src, fifo_dst, fifo_data} <= fq.pop_front();
         end
         if (wr_en) fq.push_back(wr_pkt);
         fifo_emptyp <= (fq.size() == 0);
         fifo_level  <= fq.size();
      end
   end

   // Monitor: records handshakes, pops and drop cycles at the falling edge.
   int          cyc = 0;
   int          n_read = 0;
   int          n_drop = 0;
   logic [47:0] got_q[$];
   int          hs_cyc[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (fifo_readp === 1'b1) n_read = n_read + 1;
      if (drop_pulse === 1'b1) n_drop = n_drop + 1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         got_q.push_back({out_src, out_dst, out_data});
         hs_cyc.push_back(cyc);
      end
   end

   // Reference state and counters.
   int          n_chk = 0;
   int          n_err = 0;
   logic [47:0] exp_q[$];
   int          exp_drops = 0;
   int          got_rd = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit accepted(input logic [47:0] p);
      return (p[39:32] == PORT) || (p[39:32] == BCAST);
   endfunction

   task automatic push(input logic [47:0] p);
      wr_pkt = p;
      wr_en  = 1'b1;
      step();
      wr_en  = 1'b0;
   endtask

   task automatic send(input logic [47:0] p);
      push(p);
      if (accepted(p)) exp_q.push_back(p);
      else exp_drops++;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      for (int k = 0; k < bound; k++) begin
         step();
         if (fifo_emptyp && !busy) break;
      end
      chk(tag, {fifo_emptyp, busy}, 2'b10);
      repeat (2) step();
   endtask

   task automatic wait_neg_sig(input string tag, input bit want_readp, input int bound);
      bit seen = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (want_readp ? fifo_readp : out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, seen, 1'b1);
   endtask

   task automatic check_deliv(input string tag);
      chk({tag, "_count"}, got_q.size() - got_rd, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (got_rd < got_q.size()) begin
            chk(tag, got_q[got_rd], exp_q[i]);
            got_rd++;
         end
      end
      got_rd = got_q.size();
      exp_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] p;
      logic [47:0] pb;
      logic [31:0] hold;
      int          r0;
      int          d0;
      int          h0;
      int          e0;
      int          guard;

      // Reset asserted asynchronously, away from any clock edge.
      #2 rstp = 1'b1;
      #1;
      chk("rst_readp", fifo_readp, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_src",   out_src, 0);
      chk("rst_dst",   out_dst, 0);
      chk("rst_data",  out_data, 0);
      chk("rst_drop",  drop_pulse, 0);
      chk("rst_busy",  busy, 0);
`ifdef PKT_DRAIN_STATS_EN
      chk("rst_pkt_cnt",  pkt_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
`endif
      repeat (2) step();
      rstp = 1'b0;
      step();
      chk("idle_busy",  busy, 0);
      chk("idle_readp", fifo_readp, 0);

      // Single accepted packet: cycle-exact latency.
      en = 1'b1;
      out_ready = 1'b1;
      r0 = n_read;
      p = {8'h0A, 8'h01, 32'hDEADBEEF};
      push(p);
      wait_neg_sig("acc_readp_seen", 1'b1, 10);
      @(negedge clk);
      chk("acc_readp_one_cycle", fifo_readp, 0);
      chk("acc_valid_early", out_valid, 0);
      @(negedge clk);
      chk("acc_valid_3rd", out_valid, 1);
      chk("acc_src",  out_src, 8'h0A);
      chk("acc_dst",  out_dst, 8'h01);
      chk("acc_data", out_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("acc_valid_done", out_valid, 0);
      chk("acc_fifo_empty", fifo_emptyp, 1);
      step();
      exp_q.push_back(p);
      check_deliv("acc_pkt");
      chk("acc_pops", n_read - r0, 1);

      // Drop then broadcast.
      d0 = n_drop;
      e0 = exp_drops;
      send({8'h11, 8'h05, 32'h12345678});
      send({8'h22, 8'hFF, 32'hCAFEF00D});
      wait_idle("drop_idle", 40);
      chk("drop_cycles", n_drop - d0, exp_drops - e0);
      check_deliv("bcast_pkt");

      // Back-pressure: four accepted packets, ready low while stalled.
      out_ready = 1'b0;
      r0 = n_read;
      for (int i = 0; i < 4; i++) begin
         send({8'h30 + 8'(i), (i % 2 == 0) ? PORT : BCAST, $urandom()});
      end
      wait_neg_sig("bp_valid_seen", 1'b0, 20);
      hold = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid_held", out_valid, 1);
         chk("bp_data_stable", out_data, hold);
      end
      step();
      chk("bp_one_pop", n_read - r0, 1);
      chk("bp_fifo_level", fifo_level, 3);
      h0 = hs_cyc.size();
      out_ready = 1'b1;
      wait_idle("bp_idle", 60);
      check_deliv("bp_pkt");
      for (int i = h0 + 1; i < h0 + 4 && i < hs_cyc.size(); i++) begin
         chk("bp_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
      end

      // Enable dropped during CAPT: in-flight packet completes, no new pop.
      en = 1'b0;
      r0 = n_read;
      p  = {8'h41, PORT, 32'hA5A5_0001};
      pb = {8'h42, BCAST, 32'hA5A5_0002};
      push(p);
      push(pb);
      repeat (3) step();
      chk("en0_no_pop", n_read - r0, 0);
      en = 1'b1;
      wait_neg_sig("en_readp_seen", 1'b1, 10);
      @(negedge clk);
      #1 en = 1'b0;
      repeat (10) step();
      chk("en_off_one_pop", n_read - r0, 1);
      chk("en_off_fifo_kept", fifo_emptyp, 0);
      chk("en_off_idle", busy, 0);
      exp_q.push_back(p);
      check_deliv("en_inflight_pkt");
      en = 1'b1;
      wait_idle("en_resume_idle", 40);
      exp_q.push_back(pb);
      check_deliv("en_resume_pkt");

      // Mid-cycle reset while a packet waits in OUT.
      out_ready = 1'b0;
      push({8'h55, PORT, 32'h0BAD_F00D});
      wait_neg_sig("mrst_valid_seen", 1'b0, 20);
      #2 rstp = 1'b1;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy",  busy, 0);
      chk("mrst_data",  out_data, 0);
      chk("mrst_src",   out_src, 0);
      chk("mrst_dst",   out_dst, 0);
      @(negedge clk);
      #1 rstp = 1'b0;
      step();
      chk("mrst_idle_busy",  busy, 0);
      chk("mrst_idle_readp", fifo_readp, 0);
      check_deliv("mrst_lost");

      // Randomised traffic with random enable and ready.
      r0 = n_read;
      d0 = n_drop;
      e0 = exp_drops;
      for (int i = 0; i < 40; i++) begin
         guard = 0;
         while (fifo_level >= 4 && guard < 200) begin
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            step();
            guard++;
         end
         p[47:40] = 8'($urandom());
         case ($urandom_range(0, 5))
            0, 1:    p[39:32] = PORT;
            2:       p[39:32] = BCAST;
            default: p[39:32] = 8'($urandom());
         endcase
         p[31:0] = $urandom();
         out_ready = ($urandom_range(0, 3) != 0);
         en        = ($urandom_range(0, 7) != 0);
         send(p);
      end
      en = 1'b1;
      out_ready = 1'b1;
      wait_idle("rnd_idle", 300);
      check_deliv("rnd_pkt");
      chk("rnd_drops", n_drop - d0, exp_drops - e0);
      chk("rnd_pops", n_read - r0, 40);

`ifdef PKT_DRAIN_STATS_EN
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      send({8'h61, PORT,  32'h1});
      send({8'h62, 8'h07, 32'h2});
      send({8'h63, BCAST, 32'h3});
      send({8'h64, 8'h80, 32'h4});
      send({8'h65, PORT,  32'h5});
      wait_idle("stats_idle", 60);
      check_deliv("stats_pkt");
      chk("stats_pkt_cnt",  pkt_cnt, 3);
      chk("stats_drop_cnt", drop_cnt, 2);
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      chk("stats_clr_pkt",  pkt_cnt, 0);
      chk("stats_clr_drop", drop_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
